// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N one-byte requesters,
// with per-requester lock, start/rdy sequencing, ack watchdog and baud select.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for tx_rdy=1 and a held byte; samples fsel_in
// S_ISSUE   | tx_start pulse with tx_data; arms watchdog
// S_WAIT_LO | waiting for uart_tx to drop rdy; times out after TO cycles
// S_WAIT_HI | frame on the line; waiting for rdy to return high
module uart_tx_arbiter #(
  parameter int N  = 2,
  parameter int TO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_data,
  input  logic [N-1:0]     req_lock,
  output logic [N-1:0]     req_ready,
  input  logic             fsel_in,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             tx_fsel,
  input  logic             tx_rdy,
  output logic [1:0]       owner,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(TO + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LO,
    S_WAIT_HI
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    hv_q;
  logic [7:0]      hold_q [N];
  logic [7:0]      tx_data_q;
  logic            tx_fsel_q;
  logic [1:0]      owner_q;
  logic            lock_act_q;
  logic            err_q;
  logic [CW-1:0]   wd_q;

  logic            own_lock, own_hv, locked;
  logic            rr_any, cand;
  logic [1:0]      rr_idx, gsel;
  logic [7:0]      gdata;
  logic            glock;
  logic            do_grant, wd_load, wd_dec, set_err;

  // Owner-indexed lookups done by compare so any N in 2..4 fits a 2-bit owner.
  always_comb begin
    own_lock = 1'b0;
    own_hv   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == 2'(i)) begin
        own_lock = req_lock[i];
        own_hv   = hv_q[i];
      end
    end
  end

  // Search from owner+1; iterate farthest-first so the nearest hit wins.
  always_comb begin
    rr_any = 1'b0;
    rr_idx = owner_q;
    for (int k = N; k >= 1; k--) begin
      for (int i = 0; i < N; i++) begin
        if (hv_q[i] && (i == (int'(owner_q) + k) % N)) begin
          rr_any = 1'b1;
          rr_idx = 2'(i);
        end
      end
    end
  end

  // A locked owner blocks everyone else even with its own register empty.
  always_comb begin
    locked = lock_act_q & own_lock;
    if (locked) begin
      cand = own_hv;
      gsel = owner_q;
    end else begin
      cand = rr_any;
      gsel = rr_idx;
    end
  end

  always_comb begin
    gdata = 8'h00;
    glock = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gsel == 2'(i)) begin
        gdata = hold_q[i];
        glock = req_lock[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    wd_load  = 1'b0;
    wd_dec   = 1'b0;
    set_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_rdy && cand) begin
          do_grant = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_load = 1'b1;
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx_rdy) begin
          state_d = S_WAIT_HI;
        end else if (wd_q == '0) begin
          set_err = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_dec = 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (tx_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding registers: capture only when empty, so capture and grant-clear
  // of the same slot are mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      hv_q <= '0;
      for (int i = 0; i < N; i++) hold_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (do_grant && gsel == 2'(i)) begin
          hv_q[i] <= 1'b0;
        end else if (req_valid[i] && !hv_q[i]) begin
          hv_q[i]   <= 1'b1;
          hold_q[i] <= req_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q  <= 8'h00;
      owner_q    <= 2'(N - 1);
      lock_act_q <= 1'b0;
    end else if (do_grant) begin
      tx_data_q  <= gdata;
      owner_q    <= gsel;
      lock_act_q <= glock;
    end else if (state_q == S_IDLE && !own_lock) begin
      lock_act_q <= 1'b0;
    end
  end

  // Baud select only moves between frames.
  always_ff @(posedge clk) begin
    if (rst)                            tx_fsel_q <= 1'b0;
    else if (state_q == S_IDLE && tx_rdy) tx_fsel_q <= fsel_in;
  end

  // Watchdog down-counter; terminal count at zero ends WAIT_LO after TO cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (wd_load)     wd_q <= CW'(TO - 1);
      else if (wd_dec) wd_q <= wd_q - 1'b1;
      if (set_err)     err_q <= 1'b1;
    end
  end

  assign req_ready = ~hv_q;
  assign tx_start  = (state_q == S_ISSUE);
  assign tx_data   = tx_data_q;
  assign tx_fsel   = tx_fsel_q;
  assign owner     = owner_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uart_tx rdy model;
// each observed tx_start is scored against a queue of expected grants.
module tb_uart_tx_arbiter;
  localparam int N  = 2;
  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_lock;
  logic [N-1:0]     req_ready;
  logic             fsel_in;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_fsel;
  logic             tx_rdy = 1'b1;
  logic [1:0]       owner;
  logic             busy;
  logic             err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .TO(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .fsel_in   (fsel_in),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_fsel   (tx_fsel),
    .tx_rdy    (tx_rdy),
    .owner     (owner),
    .busy      (busy),
    .err       (err)
  );

  typedef struct { logic [1:0] owner; logic [7:0] data; logic fsel; } exp_t;
  typedef struct { int req; logic [7:0] data; logic fsel; logic [1:0] exp_owner; } vec_t;

  exp_t q[$];
  exp_t e;
  vec_t vecs[4];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_start = 0;
  bit   stuck = 1'b0;
  int   frame = 20;
  int   rdy_cnt = 0;
  bit   prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // uart_tx stand-in: rdy drops the cycle after start and stays low for a frame.
  always @(posedge clk) begin
    if (rdy_cnt > 0) begin
      rdy_cnt <= rdy_cnt - 1;
      if (rdy_cnt == 1) tx_rdy <= 1'b1;
    end else if (tx_start && !stuck) begin
      tx_rdy  <= 1'b0;
      rdy_cnt <= frame;
    end
  end

  always @(negedge clk) begin
    if (tx_start) begin
      n_start++;
      check("start_spacing", {30'd0, prev_start, ~tx_rdy}, 0);
      check("start_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("tx_data", tx_data, e.data);
        check("owner", owner, e.owner);
        check("tx_fsel", tx_fsel, e.fsel);
      end
    end
    prev_start = tx_start;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int r, input logic [7:0] d);
    check("ready_before_load", (req_ready >> r) & N'(1), 1);
    req_valid = req_valid | (N'(1) << r);
    req_data  = (req_data & ~((8*N)'(8'hFF) << (8*r))) | ((8*N)'(d) << (8*r));
    tick();
    req_valid = '0;
  endtask

  task automatic wait_starts(input int target, input string name);
    int i = 0;
    while (n_start < target && i < 2000) begin
      tick();
      i++;
    end
    check(name, n_start >= target, 1);
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while ((busy || !tx_rdy) && i < 2000) begin
      tick();
      i++;
    end
    check(name, busy, 0);
  endtask

  task automatic wait_rdy(input logic lvl, input string name);
    int i = 0;
    while (tx_rdy !== lvl && i < 2000) begin
      tick();
      i++;
    end
    check(name, tx_rdy, lvl);
  endtask

  initial begin
    int s;
    int sa;
    int sb;
    int i;

    vecs[0] = '{0, 8'h12, 1'b0, 2'd0};
    vecs[1] = '{1, 8'h34, 1'b1, 2'd1};
    vecs[2] = '{0, 8'h00, 1'b1, 2'd0};
    vecs[3] = '{1, 8'hFF, 1'b0, 2'd1};

    req_valid = '0;
    req_data  = '0;
    req_lock  = '0;
    fsel_in   = 1'b0;
    rst       = 1'b1;
    repeat (3) tick();
    check("rst_ready", req_ready, {N{1'b1}});
    check("rst_start", tx_start, 0);
    check("rst_data", tx_data, 0);
    check("rst_fsel", tx_fsel, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_owner", owner, N - 1);
    rst = 1'b0;
    tick();

    // Minimum latency: accept edge k, start during k+2.
    s = n_start;
    q.push_back('{2'd0, 8'h55, 1'b0});
    load(0, 8'h55);
    check("hv_set", req_ready[0], 0);
    check("no_start_k1", tx_start, 0);
    tick();
    check("latency2_start", tx_start, 1);
    check("ready_after_grant", req_ready[0], 1);
    check("busy_during", busy, 1);
    wait_rdy(1'b0, "rdy_fell");
    wait_rdy(1'b1, "rdy_rose");
    check("busy_before_fall", busy, 1);
    tick();
    check("busy_fall", busy, 0);
    check("single_count", n_start, s + 1);

    for (int v = 0; v < 4; v++) begin
      fsel_in = vecs[v].fsel;
      tick();
      s = n_start;
      q.push_back('{vecs[v].exp_owner, vecs[v].data, vecs[v].fsel});
      load(vecs[v].req, vecs[v].data);
      wait_starts(s + 1, "vec_start");
      check("vec_owner_after", owner, vecs[v].exp_owner);
      wait_idle("vec_idle");
    end
    fsel_in = 1'b0;
    tick();

    // Round robin with both requesters continuously refilled.
    s = n_start;
    for (int k = 0; k < 3; k++) begin
      q.push_back('{2'd0, 8'(32'hA0 + k), 1'b0});
      q.push_back('{2'd1, 8'(32'hB0 + k), 1'b0});
    end
    sa = 0;
    sb = 0;
    i  = 0;
    while (n_start < s + 6 && i < 2000) begin
      req_valid = '0;
      if (req_ready[0] && sa < 3) begin
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'(32'hA0 + sa);
        sa++;
      end
      if (req_ready[1] && sb < 3) begin
        req_valid[1]   = 1'b1;
        req_data[15:8] = 8'(32'hB0 + sb);
        sb++;
      end
      tick();
      i++;
    end
    req_valid = '0;
    wait_starts(s + 6, "rr_starts");
    wait_idle("rr_idle");

    // Lock: requester 1 keeps the line while requester 0 waits.
    req_lock = 2'b10;
    s = n_start;
    for (int k = 0; k < 3; k++) q.push_back('{2'd1, 8'(32'hC0 + k), 1'b0});
    load(1, 8'hC0);
    load(0, 8'hD0);
    sb = 1;
    i  = 0;
    while (n_start < s + 3 && i < 2000) begin
      req_valid = '0;
      if (req_ready[1] && sb < 3) begin
        req_valid[1]   = 1'b1;
        req_data[15:8] = 8'(32'hC0 + sb);
        sb++;
      end
      tick();
      i++;
    end
    req_valid = '0;
    wait_starts(s + 3, "lock_starts");
    wait_idle("lock_idle");
    repeat (10) tick();
    check("lock_blocks_other", n_start, s + 3);
    check("lock_d0_held", req_ready[0], 0);
    q.push_back('{2'd0, 8'hD0, 1'b0});
    req_lock = 2'b00;
    wait_starts(s + 4, "unlock_start");
    wait_idle("unlock_idle");

    // Watchdog: rdy never drops after start.
    stuck = 1'b1;
    s = n_start;
    q.push_back('{2'd1, 8'hE1, 1'b0});
    load(1, 8'hE1);
    wait_starts(s + 1, "wd_start");
    repeat (TO) tick();
    check("wd_err_pending", err, 0);
    check("wd_busy_pending", busy, 1);
    tick();
    check("wd_err", err, 1);
    check("wd_back_idle", busy, 0);
    stuck = 1'b0;
    q.push_back('{2'd0, 8'hE2, 1'b0});
    load(0, 8'hE2);
    wait_starts(s + 2, "wd_next_start");
    wait_idle("wd_next_idle");
    check("err_sticky", err, 1);

    // Baud select must hold for the whole frame.
    frame = 40;
    s = n_start;
    q.push_back('{2'd1, 8'h5A, 1'b0});
    load(1, 8'h5A);
    wait_starts(s + 1, "baud_start");
    fsel_in = 1'b1;
    i = 0;
    while (busy && i < 2000) begin
      check("fsel_hold", tx_fsel, 0);
      tick();
      i++;
    end
    check("baud_idle", busy, 0);
    tick();
    check("fsel_update", tx_fsel, 1);
    fsel_in = 1'b0;
    tick();
    check("fsel_back", tx_fsel, 0);

    // Reset while the frame is still on the line and bytes are held.
    frame = 60;
    s = n_start;
    q.push_back('{2'd0, 8'hF0, 1'b0});
    load(0, 8'hF0);
    wait_starts(s + 1, "rst_frame_start");
    load(1, 8'hF1);
    load(0, 8'hF2);
    wait_rdy(1'b0, "rst_in_wait_hi");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", req_ready, {N{1'b1}});
    check("mid_rst_err", err, 0);
    check("mid_rst_owner", owner, N - 1);
    check("mid_rst_busy", busy, 0);
    repeat (80) tick();
    check("no_start_after_rst", n_start, s + 1);
    check("mid_rst_rdy_back", tx_rdy, 1);
    frame = 20;
    q.push_back('{2'd0, 8'h77, 1'b0});
    load(0, 8'h77);
    wait_starts(s + 2, "post_rst_start");
    wait_idle("post_rst_idle");

    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
